alarm_bank: RTL and testbench

Parametrised multi-alarm engine that supersedes the single-alarm comparator and sound control path of the clock datapath. It holds `N_ALARMS` independently armed alarm slots, each with a weekday mask, and compares them against the running current time on every minute tick. It also runs one shared ring / snooze / auto-timeout state machine and drives the `Sound` line. It sits between the current-time counter (time inputs, minute tick) and the button/buzzer front end.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_bank_if.sv | 48 ++++
 rtl/alarm_slot.sv | 49 ++++
 rtl/alarm_bank.sv | 154 +++++++++++++++
 tb/tb_alarm_bank.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_pkg                                                            |
// | Shared encodings, field widths and time limits for the alarm bank.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int DAY_W  = 7;
    localparam int CNT_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

endpackage
`default_nettype wire

// File: rtl/alarm_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_bank_if                                                        |
// | Time, slot-write, button and sound signals of the alarm bank.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alarm_bank_if #(
    parameter int N_ALARMS = 4,
    parameter int IDX_W    = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
);
    import alarm_pkg::*;

    logic                MinTick;
    logic [DAY_W-1:0]    CurDay;
    logic [HOUR_W-1:0]   CurHour;
    logic [MIN_W-1:0]    CurMin;
    logic                WrEn;
    logic [IDX_W-1:0]    WrIdx;
    logic [DAY_W-1:0]    WrDays;
    logic [HOUR_W-1:0]   WrHour;
    logic [MIN_W-1:0]    WrMin;
    logic                WrArm;
    logic                Snooze;
    logic                Stop;
    logic                Mute;
    logic                Sound;
    logic                Ringing;
    logic                Snoozing;
    logic [IDX_W-1:0]    RingIdx;
    logic [2:0]          SnoozeLeft;
    logic [N_ALARMS-1:0] Armed;

    modport master (
        output MinTick, CurDay, CurHour, CurMin,
        output WrEn, WrIdx, WrDays, WrHour, WrMin, WrArm,
        output Snooze, Stop, Mute,
        input  Sound, Ringing, Snoozing, RingIdx, SnoozeLeft, Armed
    );

    modport slave (
        input  MinTick, CurDay, CurHour, CurMin,
        input  WrEn, WrIdx, WrDays, WrHour, WrMin, WrArm,
        input  Snooze, Stop, Mute,
        output Sound, Ringing, Snoozing, RingIdx, SnoozeLeft, Armed
    );

endinterface
`default_nettype wire

// File: rtl/alarm_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_slot                                                           |
// | Storage and current-time match comparator for one alarm slot.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alarm_slot
    import alarm_pkg::*;
(
    input  wire logic              Clk,
    input  wire logic              Clr,
    input  wire logic              WrEn,
    input  wire logic [DAY_W-1:0]  WrDays,
    input  wire logic [HOUR_W-1:0] WrHour,
    input  wire logic [MIN_W-1:0]  WrMin,
    input  wire logic              WrArm,
    input  wire logic [DAY_W-1:0]  CurDay,
    input  wire logic [HOUR_W-1:0] CurHour,
    input  wire logic [MIN_W-1:0]  CurMin,
    output logic                   Match,
    output logic                   Armed
);

    logic [DAY_W-1:0]  days_q;
    logic [HOUR_W-1:0] hour_q;
    logic [MIN_W-1:0]  min_q;
    logic              arm_q;

    // WrEn arrives already qualified by index and range checks
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            days_q <= '0;
            hour_q <= '0;
            min_q  <= '0;
            arm_q  <= 1'b0;
        end else if (WrEn) begin
            days_q <= WrDays;
            hour_q <= WrHour;
            min_q  <= WrMin;
            arm_q  <= WrArm;
        end
    end

    assign Match = arm_q && (|(days_q & CurDay)) &&
                   (hour_q == CurHour) && (min_q == CurMin);
    assign Armed = arm_q;

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_bank                                                           |
// | Multi-slot alarm engine with shared ring/snooze/auto-stop control.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    parameter int RING_MIN   = 5,
    parameter int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
)(
    input  wire logic   Clk,
    input  wire logic   Clr,
    alarm_bank_if.slave bus
);

    localparam logic [2:0]       c_MAX_SNOOZE = 3'(MAX_SNOOZE);
    localparam logic [CNT_W-1:0] c_SNOOZE_MIN = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] c_RING_MIN   = CNT_W'(RING_MIN);

    logic [N_ALARMS-1:0] w_match;
    logic [N_ALARMS-1:0] w_armed;
    logic                w_any;
    logic [IDX_W-1:0]    w_low_idx;
    logic                w_wr_ok;
    logic                w_disarm;
    logic [CNT_W-1:0]    w_mc_inc;

    alarm_state_t        state_q, state_d;
    logic [2:0]          sc_q, sc_d;
    logic [CNT_W-1:0]    mc_q, mc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sound_q, ringing_q, snoozing_q;
    logic [2:0]          left_q;

    assign w_wr_ok = bus.WrEn && (bus.WrHour <= MAX_HOUR) && (bus.WrMin <= MAX_MIN);

    generate
        for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_slot
            alarm_slot u_slot (
                .Clk     (Clk),
                .Clr     (Clr),
                .WrEn    (w_wr_ok && (bus.WrIdx == IDX_W'(gi))),
                .WrDays  (bus.WrDays),
                .WrHour  (bus.WrHour),
                .WrMin   (bus.WrMin),
                .WrArm   (bus.WrArm),
                .CurDay  (bus.CurDay),
                .CurHour (bus.CurHour),
                .CurMin  (bus.CurMin),
                .Match   (w_match[gi]),
                .Armed   (w_armed[gi])
            );
        end
    endgenerate

    // Scan high to low so the lowest matching index is the one kept
    always_comb begin
        w_any     = 1'b0;
        w_low_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_any     = 1'b1;
                w_low_idx = IDX_W'(i);
            end
        end
    end

    assign w_disarm = (state_q != IDLE) && w_wr_ok && !bus.WrArm && (bus.WrIdx == idx_q);
    assign w_mc_inc = mc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        mc_d    = mc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.MinTick && w_any) begin
                    state_d = RING;
                    idx_d   = w_low_idx;
                    sc_d    = '0;
                    mc_d    = '0;
                end
            end
            RING: begin
                if (bus.Stop) begin
                    state_d = IDLE;
                end else if (bus.Snooze && (sc_q < c_MAX_SNOOZE)) begin
                    state_d = SNOOZE;
                    sc_d    = sc_q + 1'b1;
                    mc_d    = c_SNOOZE_MIN;
                end else if (bus.MinTick) begin
                    mc_d = w_mc_inc;
                    if (w_mc_inc >= c_RING_MIN) begin
                        state_d = IDLE;
                    end
                end
            end
            SNOOZE: begin
                if (bus.Stop) begin
                    state_d = IDLE;
                end else if (bus.MinTick) begin
                    if (mc_q <= 1) begin
                        state_d = RING;
                        mc_d    = '0;
                    end else begin
                        mc_d = mc_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_disarm) begin
            state_d = IDLE;
        end
    end

    // Outputs are registered from next-state so they line up with the state
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= IDLE;
            sc_q       <= '0;
            mc_q       <= '0;
            idx_q      <= '0;
            sound_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            left_q     <= c_MAX_SNOOZE;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            mc_q       <= mc_d;
            idx_q      <= idx_d;
            sound_q    <= (state_d == RING) && !bus.Mute;
            ringing_q  <= (state_d == RING);
            snoozing_q <= (state_d == SNOOZE);
            left_q     <= c_MAX_SNOOZE - sc_d;
        end
    end

    assign bus.Sound      = sound_q;
    assign bus.Ringing    = ringing_q;
    assign bus.Snoozing   = snoozing_q;
    assign bus.RingIdx    = idx_q;
    assign bus.SnoozeLeft = left_q;
    assign bus.Armed      = w_armed;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alarm_bank                                                        |
// | Directed scoreboard bench for the alarm bank.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alarm_bank;

    localparam logic [6:0] c_SUN = 7'b0000001;
    localparam logic [6:0] c_MON = 7'b0000010;
    localparam logic [6:0] c_SAT = 7'b1000000;
    localparam logic [6:0] c_ALL = 7'b1111111;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    logic Clk;
    logic Clr;
    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    logic [3:0] arm_m;

    alarm_bank_if #(.N_ALARMS(4), .IDX_W(2)) bus ();

    alarm_bank #(
        .N_ALARMS   (4),
        .SNOOZE_MIN (9),
        .MAX_SNOOZE (3),
        .RING_MIN   (5)
    ) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    // Packed view: {Ringing, Snoozing, Sound, RingIdx[1:0], SnoozeLeft[2:0], Armed[3:0]}
    function automatic logic [11:0] ev(input logic r, input logic s, input logic snd,
                                       input logic [1:0] idx, input logic [2:0] left,
                                       input logic [3:0] arm);
        return {r, s, snd, idx, left, arm};
    endfunction

    task automatic push(input string tag, input logic [11:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
    endtask

    task automatic check();
        exp_t        x;
        logic [11:0] obs;
        obs = {bus.Ringing, bus.Snoozing, bus.Sound, bus.RingIdx, bus.SnoozeLeft, bus.Armed};
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %b expected an entry", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.v) else begin
                n_err++;
                $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
            end
        end
    endtask

    task automatic step(input string tag, input logic [11:0] e);
        push(tag, e);
        @(posedge Clk);
        #1;
        bus.MinTick = 1'b0;
        bus.WrEn    = 1'b0;
        bus.Snooze  = 1'b0;
        bus.Stop    = 1'b0;
        check();
    endtask

    task automatic set_wr(input logic [1:0] idx, input logic [6:0] days,
                          input logic [4:0] h, input logic [5:0] m, input logic arm);
        bus.WrEn   = 1'b1;
        bus.WrIdx  = idx;
        bus.WrDays = days;
        bus.WrHour = h;
        bus.WrMin  = m;
        bus.WrArm  = arm;
    endtask

    task automatic set_tick(input logic [6:0] day, input logic [4:0] h, input logic [5:0] m);
        bus.MinTick = 1'b1;
        bus.CurDay  = day;
        bus.CurHour = h;
        bus.CurMin  = m;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        arm_m = 4'b0000;
        Clr   = 1'b0;
        bus.MinTick = 1'b0; bus.CurDay = '0; bus.CurHour = '0; bus.CurMin = '0;
        bus.WrEn = 1'b0; bus.WrIdx = '0; bus.WrDays = '0; bus.WrHour = '0;
        bus.WrMin = '0; bus.WrArm = 1'b0;
        bus.Snooze = 1'b0; bus.Stop = 1'b0; bus.Mute = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Clr = 1'b1;
        step("reset", ev(0, 0, 0, 2'd0, 3'd3, arm_m));

        // Basic ring and stop
        set_wr(2'd2, c_MON, 5'd7, 6'd30, 1'b1); arm_m = 4'b0100;
        step("wr_slot2", ev(0, 0, 0, 2'd0, 3'd3, arm_m));
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_basic", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        bus.Stop = 1'b1;
        step("stop_basic", ev(0, 0, 0, 2'd2, 3'd3, arm_m));

        // Day mask and lowest-index priority
        set_wr(2'd0, c_SAT, 5'd6, 6'd0, 1'b1); arm_m = 4'b0101;
        step("wr_slot0", ev(0, 0, 0, 2'd2, 3'd3, arm_m));
        set_wr(2'd3, c_ALL, 5'd6, 6'd0, 1'b1); arm_m = 4'b1101;
        step("wr_slot3", ev(0, 0, 0, 2'd2, 3'd3, arm_m));
        set_tick(c_MON, 5'd6, 6'd0);
        step("ring_mon_idx3", ev(1, 0, 1, 2'd3, 3'd3, arm_m));
        bus.Stop = 1'b1;
        step("stop_idx3", ev(0, 0, 0, 2'd3, 3'd3, arm_m));
        set_tick(c_SAT, 5'd6, 6'd0);
        step("ring_sat_idx0", ev(1, 0, 1, 2'd0, 3'd3, arm_m));
        bus.Stop = 1'b1;
        step("stop_idx0", ev(0, 0, 0, 2'd0, 3'd3, arm_m));
        set_tick(c_SUN, 5'd7, 6'd30);
        step("day_mask_miss", ev(0, 0, 0, 2'd0, 3'd3, arm_m));

        // Snooze sequence, matches during the event are ignored
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_for_snooze", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        for (int k = 0; k < 3; k++) begin
            bus.Snooze = 1'b1;
            step("snooze_enter", ev(0, 1, 0, 2'd2, 3'(2 - k), arm_m));
            for (int j = 0; j < 8; j++) begin
                set_tick(c_MON, 5'd7, 6'd30);
                step("snooze_wait", ev(0, 1, 0, 2'd2, 3'(2 - k), arm_m));
            end
            set_tick(c_MON, 5'd7, 6'd30);
            step("snooze_expire", ev(1, 0, 1, 2'd2, 3'(2 - k), arm_m));
        end
        bus.Snooze = 1'b1;
        step("snooze_exhausted", ev(1, 0, 1, 2'd2, 3'd0, arm_m));
        bus.Stop = 1'b1;
        step("stop_after_snooze", ev(0, 0, 0, 2'd2, 3'd0, arm_m));

        // Mute and auto-stop
        bus.Mute = 1'b1;
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_muted", ev(1, 0, 0, 2'd2, 3'd3, arm_m));
        for (int j = 1; j <= 3; j++) begin
            set_tick(c_MON, 5'd7, 6'd31);
            step("ring_muted_tick", ev(1, 0, 0, 2'd2, 3'd3, arm_m));
        end
        bus.Mute = 1'b0;
        set_tick(c_MON, 5'd7, 6'd31);
        step("ring_unmuted_tick4", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        set_tick(c_MON, 5'd7, 6'd31);
        step("auto_stop", ev(0, 0, 0, 2'd2, 3'd3, arm_m));

        // Simultaneous buttons and invalid writes
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_again", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        bus.Stop = 1'b1; bus.Snooze = 1'b1;
        step("stop_beats_snooze", ev(0, 0, 0, 2'd2, 3'd3, arm_m));
        set_wr(2'd1, c_ALL, 5'd24, 6'd0, 1'b1);
        step("bad_hour_dropped", ev(0, 0, 0, 2'd2, 3'd3, arm_m));
        set_wr(2'd1, c_ALL, 5'd7, 6'd60, 1'b1);
        step("bad_min_dropped", ev(0, 0, 0, 2'd2, 3'd3, arm_m));

        // Disarm the owning slot while snoozing
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_for_disarm", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        bus.Snooze = 1'b1;
        step("snooze_for_disarm", ev(0, 1, 0, 2'd2, 3'd2, arm_m));
        set_wr(2'd2, c_MON, 5'd7, 6'd30, 1'b0); arm_m = 4'b1001;
        step("disarm_to_idle", ev(0, 0, 0, 2'd2, 3'd2, arm_m));

        // Asynchronous reset in the middle of a snooze
        set_wr(2'd2, c_MON, 5'd7, 6'd30, 1'b1); arm_m = 4'b1101;
        step("rearm_slot2", ev(0, 0, 0, 2'd2, 3'd2, arm_m));
        set_tick(c_MON, 5'd7, 6'd30);
        step("ring_for_reset", ev(1, 0, 1, 2'd2, 3'd3, arm_m));
        bus.Snooze = 1'b1;
        step("snooze_for_reset", ev(0, 1, 0, 2'd2, 3'd2, arm_m));
        #2;
        Clr = 1'b0;
        arm_m = 4'b0000;
        #1;
        push("async_reset", ev(0, 0, 0, 2'd0, 3'd3, arm_m));
        check();
        #2;
        Clr = 1'b1;
        set_tick(c_MON, 5'd7, 6'd30);
        step("slots_cleared_mon", ev(0, 0, 0, 2'd0, 3'd3, arm_m));
        set_tick(c_SAT, 5'd6, 6'd0);
        step("slots_cleared_sat", ev(0, 0, 0, 2'd0, 3'd3, arm_m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
